// File: rtl/mac_accumulator_pkg.sv
// Shared widths and FSM state encodings for the multiply-accumulate block.
package mac_accumulator_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_accumulator_arraymultiplier.sv
// 4x4 unsigned array multiplier: {co, p} = a*b + si + ci, built from shifted partial-product rows.
module arraymultiplier
  import mac_accumulator_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              si,
  input  logic              ci,
  output logic [PROD_W-1:0] p,
  output logic              co
);

  logic [PROD_W:0] sum;

  always_comb begin
    sum = {{PROD_W{1'b0}}, si} + {{PROD_W{1'b0}}, ci};
    for (int i = 0; i < OP_W; i++) begin
      sum = sum + ({{(PROD_W + 1 - OP_W){1'b0}}, a & {OP_W{b[i]}}} << i);
    end
  end

  assign p  = sum[PROD_W-1:0];
  assign co = sum[PROD_W];

endmodule

// File: rtl/mac_accumulator.sv
// Job-oriented multiply-accumulate: sums len products a*b through a one-deep product
// register, then presents the total until the consumer takes it.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               prod_v_q, prod_v_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;

  logic [PROD_W-1:0]  mult_p;
  logic               mult_co_unused;
  logic [ACC_W:0]     acc_sum;
  logic               accept;

  arraymultiplier u_mult (
    .a  (a),
    .b  (b),
    .si (1'b0),
    .ci (1'b0),
    .p  (mult_p),
    .co (mult_co_unused)
  );

  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};
  assign accept  = (state_q == ACCUM) && in_valid;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    prod_v_d = prod_v_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;

    // Stage 2: fold the registered product into the accumulator.
    if (prod_v_q) begin
      acc_d    = acc_sum[ACC_W-1:0];
      ovf_d    = ovf_q | acc_sum[ACC_W];
      prod_v_d = 1'b0;
    end

    // Stage 1: capture a new product; may overlap the fold above.
    if (accept) begin
      prod_d   = mult_p;
      prod_v_d = 1'b1;
      rem_d    = rem_q - LEN_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            rem_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: if (accept && rem_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a 16-bit and an 8-bit accumulator share stimulus and are
// compared against job-level sums computed by the bench.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  len;
  logic [3:0]  a, b;

  logic        in_ready16, out_valid16, overflow16, busy16;
  logic [15:0] acc16;
  logic        in_ready8, out_valid8, overflow8, busy8;
  logic [7:0]  acc8;

  int n_vec = 0;
  int n_err = 0;
  int da[8];
  int db[8];

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready16), .acc_out(acc16),
    .out_valid(out_valid16), .out_ready(out_ready), .overflow(overflow16), .busy(busy16)
  );

  mac_accumulator #(.ACC_W(8), .LEN_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready8), .acc_out(acc8),
    .out_valid(out_valid8), .out_ready(out_ready), .overflow(overflow8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input bit rdy, input bit vld, input bit bsy);
    chk({tag, "_in_ready16"}, in_ready16, rdy);
    chk({tag, "_in_ready8"}, in_ready8, rdy);
    chk({tag, "_out_valid16"}, out_valid16, vld);
    chk({tag, "_out_valid8"}, out_valid8, vld);
    chk({tag, "_busy16"}, busy16, bsy);
    chk({tag, "_busy8"}, busy8, bsy);
  endtask

  task automatic chk_result(input string tag, input int sum);
    chk({tag, "_acc16"}, acc16, sum % 65536);
    chk({tag, "_acc8"}, acc8, sum % 256);
    chk({tag, "_ovf16"}, overflow16, sum >= 65536);
    chk({tag, "_ovf8"}, overflow8, sum >= 256);
  endtask

  // One job: start, feed jlen beats (directed from da/db or random), drain, hold, release.
  task automatic run_job(input string tag, input int jlen, input bit directed,
                         input int gap_pct, input int hold);
    int  sum = 0;
    int  cnt = 0;
    int  cyc = 0;
    bit  take;
    out_ready = 1'b0;
    start     = 1'b1;
    len       = 8'(jlen);
    tick();
    start = 1'b0;
    len   = 8'($urandom);
    if (jlen == 0) begin
      chk_ctrl({tag, "_len0"}, 1'b0, 1'b1, 1'b1);
    end else begin
      while (cnt < jlen) begin
        if (cyc > 2000) begin
          chk({tag, "_timeout"}, 0, 1);
          break;
        end
        chk_ctrl({tag, "_accum"}, 1'b1, 1'b0, 1'b1);
        start = 1'($urandom);
        len   = 8'($urandom);
        if (directed) begin
          in_valid = (cyc % 2 == 0);
          a = in_valid ? 4'(da[cnt]) : 4'($urandom);
          b = in_valid ? 4'(db[cnt]) : 4'($urandom);
        end else begin
          in_valid = ($urandom_range(0, 99) >= gap_pct);
          a = 4'($urandom);
          b = 4'($urandom);
        end
        take = in_valid && in_ready16;
        tick();
        cyc++;
        if (take) begin
          sum += int'(a) * int'(b);
          cnt++;
        end
      end
      in_valid = 1'b1;
      a = 4'($urandom);
      b = 4'($urandom);
      start = 1'b1;
      chk_ctrl({tag, "_drain"}, 1'b0, 1'b0, 1'b1);
      tick();
    end
    chk_ctrl({tag, "_done"}, 1'b0, 1'b1, 1'b1);
    chk_result({tag, "_done"}, sum);
    for (int i = 0; i < hold; i++) begin
      start    = (i % 2 == 0);
      in_valid = 1'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      tick();
      chk_ctrl({tag, "_hold"}, 1'b0, 1'b1, 1'b1);
      chk_result({tag, "_hold"}, sum);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_ctrl({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
    chk({tag, "_idle_acc16"}, acc16, sum % 65536);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; a = '0; b = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_acc16", acc16, 0);
    chk("reset_acc8", acc8, 0);
    chk("reset_ovf16", overflow16, 0);
    rst = 1'b0;
    tick();
    chk_ctrl("post_reset", 1'b0, 1'b0, 1'b0);

    da[0] = 15; db[0] = 15;
    run_job("single", 1, 1'b1, 0, 0);

    da[0] = 3; db[0] = 5; da[1] = 7; db[1] = 2;
    da[2] = 0; db[2] = 9; da[3] = 15; db[3] = 1;
    run_job("four", 4, 1'b1, 0, 1);

    run_job("zero", 0, 1'b0, 0, 2);

    da[0] = 15; db[0] = 15; da[1] = 15; db[1] = 15;
    run_job("wrap8", 2, 1'b1, 0, 5);

    // Abort mid-job with a third beat on the wire.
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0; in_valid = 1'b1; a = 4'd9; b = 4'd9;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk_ctrl("abort", 1'b0, 1'b0, 1'b0);
    chk("abort_acc16", acc16, 0);
    chk("abort_acc8", acc8, 0);
    chk("abort_ovf8", overflow8, 0);
    tick();
    chk("abort_settled_acc16", acc16, 0);
    da[0] = 2; db[0] = 3;
    run_job("after_abort", 1, 1'b1, 0, 0);

    for (int j = 0; j < 20; j++) begin
      run_job("rand", $urandom_range(0, 40), 1'b0, 30, $urandom_range(0, 3));
    end
    run_job("rand_long", 255, 1'b0, 10, 1);
    run_job("rand_burst", 30, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
